// File: rtl/dcache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dcache_write_buffer
// Description : Writeback FIFO between the data cache and the AXI bridge
//               d_w* port. Stores dirty-line / uncached store requests,
//               drains them one at a time with a one-cycle gap between
//               offers, and flags address hazards against pending entries.
//               Optional macro WBUF_FWD_EN: forward the youngest matching
//               entry's data on chk_data (otherwise chk_data is zero).
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_write_buffer #(
    parameter int DEPTH    = 4,
    parameter int LINE_OFF = 6
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         wb_valid,
    output logic         wb_ready,
    input  logic [31:0]  wb_addr,
    input  logic [511:0] wb_data,
    input  logic [7:0]   wb_len,
    input  logic [2:0]   wb_size,
    input  logic [3:0]   wb_strb,
    output logic [31:0]  d_waddr,
    output logic [511:0] d_wdata,
    output logic [7:0]   d_wlen,
    output logic [2:0]   d_wsize,
    output logic [3:0]   d_wstrb,
    output logic         d_wvalid,
    input  logic         d_wready,
    input  logic [31:0]  chk_addr,
    output logic         chk_hit,
    output logic [511:0] chk_data,
    output logic         empty
);

    localparam int                PTR_W     = $clog2(DEPTH);
    localparam int                CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  C_FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  C_CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]  C_PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_ISSUE = 2'd1,
        D_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_addr [DEPTH];
    logic [511:0]       r_data [DEPTH];
    logic [7:0]         r_len  [DEPTH];
    logic [2:0]         r_size [DEPTH];
    logic [3:0]         r_strb [DEPTH];

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [DEPTH-1:0]   w_valid;
    logic [DEPTH-1:0]   w_match;
    logic               w_unused_line_off;

    // Full blocks pushes even when the head pops in the same cycle.
    assign w_full   = (r_count == C_FULL);
    assign wb_ready = ~w_full;
    assign w_push   = wb_valid & ~w_full;
    assign w_pop    = (r_state == D_ISSUE) & d_wready;
    assign empty    = (r_count == '0) & ~d_wvalid;

    // Head entry drives the bridge directly.
    assign d_waddr = r_addr[r_rd_ptr];
    assign d_wdata = r_data[r_rd_ptr];
    assign d_wlen  = r_len[r_rd_ptr];
    assign d_wsize = r_size[r_rd_ptr];
    assign d_wstrb = r_strb[r_rd_ptr];

    // Within-line offset bits take no part in the hazard compare.
    assign w_unused_line_off = ^chk_addr[LINE_OFF-1:0];

    // Payload storage, written at wr_ptr on an accepted push.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= wb_addr;
            r_data[r_wr_ptr] <= wb_data;
            r_len[r_wr_ptr]  <= wb_len;
            r_size[r_wr_ptr] <= wb_size;
            r_strb[r_wr_ptr] <= wb_strb;
        end
    end

    // Pointers and occupancy; reset discards everything pending.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Drain state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= D_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain next-state and offer: issue, wait for completion, one idle gap.
    always_comb begin
        w_state_nxt = r_state;
        d_wvalid    = 1'b0;
        case (r_state)
            D_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = D_ISSUE;
                end
            end
            D_ISSUE: begin
                d_wvalid = 1'b1;
                if (d_wready) begin
                    w_state_nxt = D_GAP;
                end
            end
            D_GAP: begin
                w_state_nxt = (r_count != '0) ? D_ISSUE : D_IDLE;
            end
            default: begin
                w_state_nxt = D_IDLE;
            end
        endcase
    end

    // An entry is live when its distance from rd_ptr is below count.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] w_age;
            assign w_age       = PTR_W'(gi) - r_rd_ptr;
            assign w_valid[gi] = ({1'b0, w_age} < r_count);
            assign w_match[gi] = w_valid[gi] &
                                 (r_addr[gi][31:LINE_OFF] == chk_addr[31:LINE_OFF]);
        end
    endgenerate

    assign chk_hit = |w_match;

`ifdef WBUF_FWD_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        chk_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_match[r_rd_ptr + PTR_W'(k)]) begin
                chk_data = r_data[r_rd_ptr + PTR_W'(k)];
            end
        end
    end
`else
    assign chk_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_write_buffer
// Description : Self-checking bench for dcache_write_buffer: directed
//               scenarios plus randomized traffic against a queue model.
//               Honours WBUF_FWD_EN for chk_data expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_write_buffer;

    localparam int DEPTH    = 4;
    localparam int LINE_OFF = 6;

    logic         aclk;
    logic         aresetn;
    logic         wb_valid;
    logic         wb_ready;
    logic [31:0]  wb_addr;
    logic [511:0] wb_data;
    logic [7:0]   wb_len;
    logic [2:0]   wb_size;
    logic [3:0]   wb_strb;
    logic [31:0]  d_waddr;
    logic [511:0] d_wdata;
    logic [7:0]   d_wlen;
    logic [2:0]   d_wsize;
    logic [3:0]   d_wstrb;
    logic         d_wvalid;
    logic         d_wready;
    logic [31:0]  chk_addr;
    logic         chk_hit;
    logic [511:0] chk_data;
    logic         empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [511:0] data;
        logic [7:0]   len;
        logic [2:0]   size;
        logic [3:0]   strb;
    } ent_t;

    dcache_write_buffer #(.DEPTH(DEPTH), .LINE_OFF(LINE_OFF)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_len   (wb_len),
        .wb_size  (wb_size),
        .wb_strb  (wb_strb),
        .d_waddr  (d_waddr),
        .d_wdata  (d_wdata),
        .d_wlen   (d_wlen),
        .d_wsize  (d_wsize),
        .d_wstrb  (d_wstrb),
        .d_wvalid (d_wvalid),
        .d_wready (d_wready),
        .chk_addr (chk_addr),
        .chk_hit  (chk_hit),
        .chk_data (chk_data),
        .empty    (empty)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        wb_valid = 1'b0;
        d_wready = 1'b0;
        aresetn  = 1'b0;
        repeat (2) tick();
        aresetn  = 1'b1;
        tick();
    endtask

    task automatic push(input logic [31:0] a, input logic [511:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        wb_len   = 8'd15;
        wb_size  = 3'd2;
        wb_strb  = 4'hf;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic wait_wvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (d_wvalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (d_wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b expected 0", d_wvalid); end
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_wb_ready: got %b expected 1", wb_ready); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL reset_chk_hit: got %b expected 0", chk_hit); end
        do_reset();
    endtask

    task automatic test_single();
        logic [511:0] d;
        d = rand_line();
        do_reset();
        wb_valid = 1'b1; wb_addr = 32'h1000_0040; wb_data = d;
        wb_len = 8'd15; wb_size = 3'd6; wb_strb = 4'hf;
        tick();
        wb_valid = 1'b0;
        checks++; if (d_wvalid !== 1'b0) begin errors++; $display("FAIL single_wvalid_early: got %b expected 0", d_wvalid); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_not_empty: got %b expected 0", empty); end
        tick();
        checks++; if (d_wvalid !== 1'b1) begin errors++; $display("FAIL single_wvalid: got %b expected 1", d_wvalid); end
        checks++; if (d_waddr !== 32'h1000_0040) begin errors++; $display("FAIL single_waddr: got %h expected 10000040", d_waddr); end
        checks++; if (d_wlen !== 8'd15 || d_wsize !== 3'd6 || d_wstrb !== 4'hf) begin errors++; $display("FAIL single_attr: got len %0d size %0d strb %h expected 15 6 f", d_wlen, d_wsize, d_wstrb); end
        checks++; if (d_wdata !== d) begin errors++; $display("FAIL single_wdata: got %h expected %h", d_wdata[63:0], d[63:0]); end
        tick();
        checks++; if (d_wvalid !== 1'b1 || d_waddr !== 32'h1000_0040) begin errors++; $display("FAIL single_hold: got %b/%h expected 1/10000040", d_wvalid, d_waddr); end
        d_wready = 1'b1;
        tick();
        d_wready = 1'b0;
        checks++; if (d_wvalid !== 1'b0) begin errors++; $display("FAIL single_wvalid_drop: got %b expected 0", d_wvalid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", empty); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a[i] = 32'h5000_0000 + 32'(i) * 32'h100;
            push(a[i], rand_line());
        end
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got wb_ready %b expected 0", wb_ready); end
        wb_valid = 1'b1; wb_addr = 32'h5BAD_0000;
        repeat (2) tick();
        checks++; if (wb_ready !== 1'b0 || d_waddr !== a[0]) begin errors++; $display("FAIL b2b_held: got %b/%h expected 0/%h", wb_ready, d_waddr, a[0]); end
        wb_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (d_wvalid !== 1'b1 || d_waddr !== a[i]) begin errors++; $display("FAIL b2b_order: got %b/%h expected 1/%h", d_wvalid, d_waddr, a[i]); end
            d_wready = 1'b1;
            tick();
            d_wready = 1'b0;
            checks++; if (d_wvalid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b expected 0", d_wvalid); end
            tick();
        end
        checks++; if (d_wvalid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL b2b_drained: got %b/%b expected 0/1", d_wvalid, empty); end
    endtask

    task automatic test_hazard();
        bit ok;
        do_reset();
        wb_valid = 1'b1; wb_addr = 32'h2000_0000; wb_data = rand_line();
        chk_addr = 32'h2000_003C;
        #1;
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL haz_same_cycle: got %b expected 0", chk_hit); end
        tick();
        wb_addr = 32'h2000_0020; wb_data = rand_line();
        tick();
        wb_valid = 1'b0;
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL haz_hit: got %b expected 1", chk_hit); end
        chk_addr = 32'h2000_0040; #1;
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL haz_next_line: got %b expected 0", chk_hit); end
        chk_addr = 32'h1FFF_FFC0; #1;
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL haz_prev_line: got %b expected 0", chk_hit); end
        chk_addr = 32'h2000_003C;
        wait_wvalid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL haz_wait1: got timeout expected d_wvalid"); end
        d_wready = 1'b1; tick(); d_wready = 1'b0;
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL haz_one_left: got %b expected 1", chk_hit); end
        wait_wvalid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL haz_wait2: got timeout expected d_wvalid"); end
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL haz_head_pending: got %b expected 1", chk_hit); end
        d_wready = 1'b1; tick(); d_wready = 1'b0;
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL haz_drained: got %b expected 0", chk_hit); end
    endtask

    task automatic test_forward();
        logic [511:0] d1, d2, exp;
        d1 = rand_line();
        d2 = rand_line();
        do_reset();
        push(32'h3000_0000, d1);
        push(32'h3000_0010, d2);
        chk_addr = 32'h3000_0004; #1;
`ifdef WBUF_FWD_EN
        exp = d2;
`else
        exp = '0;
`endif
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit: got %b expected 1", chk_hit); end
        checks++; if (chk_data !== exp) begin errors++; $display("FAIL fwd_data: got %h expected %h", chk_data[63:0], exp[63:0]); end
        chk_addr = 32'h3000_1000; #1;
        checks++; if (chk_data !== 512'd0 || chk_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss: got %b/%h expected 0/0", chk_hit, chk_data[63:0]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit quiet;
        do_reset();
        for (int i = 0; i < 3; i++) push(32'h6000_0000 + 32'(i) * 32'h40, rand_line());
        wait_wvalid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_wait: got timeout expected d_wvalid"); end
        chk_addr = 32'h6000_0000;
        aresetn = 1'b0;
        #1;
        checks++; if (d_wvalid !== 1'b0) begin errors++; $display("FAIL rstmid_wvalid: got %b expected 0", d_wvalid); end
        checks++; if (empty !== 1'b1 || wb_ready !== 1'b1) begin errors++; $display("FAIL rstmid_flags: got empty %b wb_ready %b expected 1 1", empty, wb_ready); end
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL rstmid_hit: got %b expected 0", chk_hit); end
        repeat (2) tick();
        aresetn = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (d_wvalid !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL rstmid_no_issue: got d_wvalid after release expected none"); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] a [4];
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a[i] = 32'h7000_0000 + 32'(i) * 32'h40;
            push(a[i], rand_line());
        end
        wait_wvalid(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fpp_wait: got timeout expected d_wvalid"); end
        wb_valid = 1'b1; wb_addr = 32'h7FFF_0000; d_wready = 1'b1;
        #1;
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL fpp_refuse: got wb_ready %b expected 0", wb_ready); end
        tick();
        wb_valid = 1'b0; d_wready = 1'b0;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL fpp_ready_after: got %b expected 1", wb_ready); end
        for (int j = 1; j < 4; j++) begin
            wait_wvalid(ok);
            checks++; if (!ok || d_waddr !== a[j]) begin errors++; $display("FAIL fpp_order: got %b/%h expected 1/%h", ok, d_waddr, a[j]); end
            d_wready = 1'b1; tick(); d_wready = 1'b0;
        end
        repeat (2) tick();
        checks++; if (empty !== 1'b1 || d_wvalid !== 1'b0) begin errors++; $display("FAIL fpp_count3: got empty %b wvalid %b expected 1 0", empty, d_wvalid); end
    endtask

    task automatic test_random();
        ent_t         q[$];
        ent_t         e;
        bit           offer;
        bit           hit;
        logic [511:0] fd;
        int           sz;
        offer = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            wb_valid = ($urandom_range(0, 2) != 0);
            wb_addr  = 32'h4000_0000 + 32'($urandom_range(0, 5)) * 32'h40 + 32'($urandom_range(0, 63));
            wb_data  = rand_line();
            wb_len   = 8'($urandom);
            wb_size  = 3'($urandom);
            wb_strb  = 4'($urandom);
            d_wready = ($urandom_range(0, 3) == 0);
            chk_addr = 32'h4000_0000 + 32'($urandom_range(0, 6)) * 32'h40 + 32'($urandom_range(0, 63));
            #1;
            sz  = q.size();
            hit = 1'b0;
            fd  = '0;
            foreach (q[i]) begin
                if (q[i].addr[31:LINE_OFF] == chk_addr[31:LINE_OFF]) begin
                    hit = 1'b1;
                    fd  = q[i].data;
                end
            end
`ifndef WBUF_FWD_EN
            fd = '0;
`endif
            checks++; if (wb_ready !== (sz < DEPTH)) begin errors++; $display("FAIL rnd_wb_ready cyc %0d: got %b expected %b", cyc, wb_ready, sz < DEPTH); end
            checks++; if (d_wvalid !== offer) begin errors++; $display("FAIL rnd_wvalid cyc %0d: got %b expected %b", cyc, d_wvalid, offer); end
            checks++; if (empty !== (sz == 0 && !offer)) begin errors++; $display("FAIL rnd_empty cyc %0d: got %b expected %b", cyc, empty, sz == 0 && !offer); end
            checks++; if (chk_hit !== hit) begin errors++; $display("FAIL rnd_chk_hit cyc %0d: got %b expected %b", cyc, chk_hit, hit); end
            checks++; if (chk_data !== fd) begin errors++; $display("FAIL rnd_chk_data cyc %0d: got %h expected %h", cyc, chk_data[63:0], fd[63:0]); end
            if (offer) begin
                checks++;
                if (d_waddr !== q[0].addr || d_wdata !== q[0].data || d_wlen !== q[0].len ||
                    d_wsize !== q[0].size || d_wstrb !== q[0].strb) begin
                    errors++;
                    $display("FAIL rnd_head cyc %0d: got addr %h len %0d expected addr %h len %0d", cyc, d_waddr, d_wlen, q[0].addr, q[0].len);
                end
            end
            e.addr = wb_addr; e.data = wb_data; e.len = wb_len; e.size = wb_size; e.strb = wb_strb;
            if (offer && d_wready) void'(q.pop_front());
            if (wb_valid && sz < DEPTH) q.push_back(e);
            offer = offer ? !d_wready : (sz != 0);
            @(posedge aclk);
            #1;
        end
        wb_valid = 1'b0;
        d_wready = 1'b0;
    endtask

    initial begin
        aresetn  = 1'b0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        wb_len   = '0;
        wb_size  = '0;
        wb_strb  = '0;
        d_wready = 1'b0;
        chk_addr = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hazard();
        test_forward();
        test_reset_mid();
        test_full_push_pop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
